// File: rtl/pkmc_cmd_tracker.sv
// Matches the SDRAM command bus against NCH reference commands and tracks the spacing between hits, with one cycle of latency.
// There is no backpressure: every valid cycle is evaluated, and the block never stalls the sequencer.
module pkmc_cmd_tracker #(
    parameter int CMD_W = 4,
    parameter int NCH   = 4,
    parameter int CNT_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CMD_W-1:0]     cmd_i,
    input  logic                 cmd_valid_i,
    input  logic [NCH*CMD_W-1:0] ref_cmd_i,
    input  logic [NCH-1:0]       mask_i,
    input  logic [NCH*CNT_W-1:0] min_gap_i,
    input  logic                 viol_clr_i,
    output logic [NCH-1:0]       hit_o,
    output logic                 any_hit_o,
    output logic                 multi_hit_o,
    output logic [NCH*CNT_W-1:0] gap_cnt_o,
    output logic [NCH-1:0]       ready_o,
    output logic [NCH-1:0]       viol_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NCH-1:0]            match_vec;
    logic [NCH-1:0]            ready_vec;

    logic [NCH-1:0]            hit_d,       hit_q;
    logic                      any_hit_d,   any_hit_q;
    logic                      multi_hit_d, multi_hit_q;
    logic [NCH-1:0][CNT_W-1:0] gap_cnt_d,   gap_cnt_q;
    logic [NCH-1:0]            viol_d,      viol_q;

    always_comb begin
        match_vec = '0;
        ready_vec = '0;
        for (int k = 0; k < NCH; k++) begin
            match_vec[k] = cmd_valid_i && !mask_i[k] &&
                           (cmd_i == ref_cmd_i[k*CMD_W +: CMD_W]);
            ready_vec[k] = (gap_cnt_q[k] >= min_gap_i[k*CNT_W +: CNT_W]);
        end
    end

    always_comb begin
        hit_d       = match_vec;
        any_hit_d   = |match_vec;
        // Clearing the lowest set bit leaves something only if two or more channels matched.
        multi_hit_d = |(match_vec & (match_vec - 1'b1));
        gap_cnt_d   = gap_cnt_q;
        viol_d      = viol_q;
        for (int k = 0; k < NCH; k++) begin
            if (match_vec[k]) begin
                gap_cnt_d[k] = '0;
            end else if (gap_cnt_q[k] != CNT_MAX) begin
                gap_cnt_d[k] = gap_cnt_q[k] + 1'b1;
            end
            // A new violation takes priority over a clear in the same cycle.
            if (match_vec[k] && !ready_vec[k]) begin
                viol_d[k] = 1'b1;
            end else if (viol_clr_i) begin
                viol_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_q       <= '0;
            any_hit_q   <= 1'b0;
            multi_hit_q <= 1'b0;
            gap_cnt_q   <= '1;
            viol_q      <= '0;
        end else begin
            hit_q       <= hit_d;
            any_hit_q   <= any_hit_d;
            multi_hit_q <= multi_hit_d;
            gap_cnt_q   <= gap_cnt_d;
            viol_q      <= viol_d;
        end
    end

    assign hit_o       = hit_q;
    assign any_hit_o   = any_hit_q;
    assign multi_hit_o = multi_hit_q;
    assign gap_cnt_o   = gap_cnt_q;
    assign ready_o     = ready_vec;
    assign viol_o      = viol_q;

endmodule

// File: tb/tb_pkmc_cmd_tracker.sv
// Randomised and directed bench for pkmc_cmd_tracker, checked against a timestamp-based reference model.
module tb_pkmc_cmd_tracker;

    localparam int CMD_W = 4;
    localparam int NCH   = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [CMD_W-1:0]     cmd_i = '0;
    logic                 cmd_valid_i = 1'b0;
    logic [NCH*CMD_W-1:0] ref_cmd_i = '0;
    logic [NCH-1:0]       mask_i = '0;
    logic [NCH*CNT_W-1:0] min_gap_i = '0;
    logic                 viol_clr_i = 1'b0;
    logic [NCH-1:0]       hit_o;
    logic                 any_hit_o;
    logic                 multi_hit_o;
    logic [NCH*CNT_W-1:0] gap_cnt_o;
    logic [NCH-1:0]       ready_o;
    logic [NCH-1:0]       viol_o;

    pkmc_cmd_tracker #(.CMD_W(CMD_W), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i),
        .ref_cmd_i(ref_cmd_i), .mask_i(mask_i), .min_gap_i(min_gap_i),
        .viol_clr_i(viol_clr_i), .hit_o(hit_o), .any_hit_o(any_hit_o),
        .multi_hit_o(multi_hit_o), .gap_cnt_o(gap_cnt_o), .ready_o(ready_o),
        .viol_o(viol_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: a hit timestamp per channel; the gap is elapsed edges, saturated.
    int edge_n = 0;
    int last_hit [NCH];
    bit viol_m   [NCH];
    bit hit_m    [NCH];
    bit any_m, multi_m;
    bit model_ok = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gap_m(input int k);
        int d;
        d = edge_n - last_hit[k];
        return (d > SAT) ? SAT : d;
    endfunction

    function automatic logic [NCH-1:0] ready_m();
        logic [NCH-1:0] r;
        for (int k = 0; k < NCH; k++)
            r[k] = (gap_m(k) >= int'(min_gap_i[k*CNT_W +: CNT_W]));
        return r;
    endfunction

    function automatic logic [NCH*CNT_W-1:0] gaps_m();
        logic [NCH*CNT_W-1:0] g;
        for (int k = 0; k < NCH; k++) g[k*CNT_W +: CNT_W] = CNT_W'(gap_m(k));
        return g;
    endfunction

    task automatic model_edge();
        logic [NCH-1:0] rdy;
        int n;
        rdy = ready_m();
        edge_n++;
        n = 0;
        for (int k = 0; k < NCH; k++) begin
            if (rst_i) begin
                hit_m[k]    = 0;
                viol_m[k]   = 0;
                last_hit[k] = edge_n - 1000;
            end else begin
                hit_m[k] = cmd_valid_i && !mask_i[k] && (cmd_i == ref_cmd_i[k*CMD_W +: CMD_W]);
                if (hit_m[k]) begin
                    n++;
                    last_hit[k] = edge_n;
                end
                if (hit_m[k] && !rdy[k]) viol_m[k] = 1;
                else if (viol_clr_i)     viol_m[k] = 0;
            end
        end
        any_m   = (n >= 1);
        multi_m = (n >= 2);
        if (rst_i) model_ok = 1;
    endtask

    // One clock: apply the inputs, check ready before the edge, then check all outputs after it.
    task automatic cyc(input logic rst, input logic vld, input logic [CMD_W-1:0] cmd,
                       input logic [NCH-1:0] msk, input logic clr);
        logic [NCH-1:0] h, v;
        rst_i = rst; cmd_valid_i = vld; cmd_i = cmd; mask_i = msk; viol_clr_i = clr;
        #1;
        if (model_ok) check("ready_pre", 32'(ready_o), 32'(ready_m()));
        @(posedge clk_i);
        model_edge();
        #1;
        for (int k = 0; k < NCH; k++) begin
            h[k] = hit_m[k];
            v[k] = viol_m[k];
        end
        check("hit", 32'(hit_o), 32'(h));
        check("any", 32'(any_hit_o), 32'(any_m));
        check("multi", 32'(multi_hit_o), 32'(multi_m));
        check("gap", 32'(gap_cnt_o), 32'(gaps_m()));
        check("viol", 32'(viol_o), 32'(v));
        check("ready", 32'(ready_o), 32'(ready_m()));
    endtask

    initial begin
        #2;
        // 1. Reset
        min_gap_i = {NCH{4'd3}};
        ref_cmd_i = {4'hA, 4'h5, 4'h5, 4'h3};
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("rst_gap15", 32'(gap_cnt_o), 32'hFFFF);
        check("rst_ready", 32'(ready_o), 32'hF);
        check("rst_hit", 32'(hit_o), 32'h0);

        // 2. Single hit on channel 0
        cyc(0, 1, 4'h3, 0, 0);
        check("single_hit", 32'(hit_o), 32'h1);
        check("single_gap0", 32'(gap_cnt_o[3:0]), 32'h0);
        cyc(0, 0, 0, 0, 0);
        check("single_gap1", 32'(gap_cnt_o[3:0]), 32'h1);

        // 3. Gap violation, clear, clear coincident with a new violation
        cyc(0, 1, 4'h3, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 4'h3, 0, 0);
        check("viol_set", 32'(viol_o[0]), 32'h1);
        cyc(0, 0, 0, 0, 1);
        check("viol_clr", 32'(viol_o[0]), 32'h0);
        cyc(0, 1, 4'h3, 0, 1);
        cyc(0, 1, 4'h3, 0, 1);
        check("viol_setwins", 32'(viol_o[0]), 32'h1);

        // 4. Mask, duplicate references, saturation
        cyc(0, 1, 4'h5, 4'b0100, 0);
        check("mask_hit", 32'(hit_o), 32'h2);
        cyc(0, 1, 4'h5, 4'b0000, 0);
        check("dup_hit", 32'(hit_o), 32'h6);
        check("dup_multi", 32'(multi_hit_o), 32'h1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
        check("sat_gap", 32'(gap_cnt_o), 32'hFFFF);

        // 5. Back-to-back with min_gap 0, then an invalid matching command
        min_gap_i[3:0] = 4'd0;
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'h3, 0, 0);
        check("b2b_noviol", 32'(viol_o[0]), 32'h0);
        cyc(0, 0, 4'h3, 0, 0);
        check("invalid_nohit", 32'(hit_o), 32'h0);

        // 6. Reset the cycle after a match
        cyc(0, 1, 4'h3, 0, 0);
        cyc(1, 1, 4'h3, 0, 0);
        check("midrst_gap", 32'(gap_cnt_o), 32'hFFFF);

        // Randomised traffic drawn from a small command alphabet so hits are frequent
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) ref_cmd_i = NCH*CMD_W'($urandom_range(0, 65535) & 16'h3333);
            if ($urandom_range(0, 7) == 0)  min_gap_i = NCH*CNT_W'($urandom_range(0, 65535) & 16'h7777);
            cyc($urandom_range(0, 60) == 0,
                $urandom_range(0, 3) != 0,
                CMD_W'($urandom_range(0, 3)),
                NCH'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0),
                $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
